// File: rtl/if_mem_if.sv
// if_mem_if: signal bundle between IF, instruction memory and decode around if_mem.
// fault_o exists only when IF_MEM_MISALIGN_EN is defined.
interface if_mem_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_i, imem_addr_o, imem_rdata_i, pc_o, instr_o;
    logic valid_i, ready_o, imem_req_o, imem_gnt_i, imem_rvalid_i, flush_i, valid_o, ready_i;
`ifdef IF_MEM_MISALIGN_EN
    logic fault_o;
    modport slave (
        input  pc_i, valid_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, flush_i, ready_i,
        output ready_o, imem_req_o, imem_addr_o, valid_o, pc_o, instr_o, fault_o
    );
    modport master (
        output pc_i, valid_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, flush_i, ready_i,
        input  ready_o, imem_req_o, imem_addr_o, valid_o, pc_o, instr_o, fault_o
    );
`else
    modport slave (
        input  pc_i, valid_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, flush_i, ready_i,
        output ready_o, imem_req_o, imem_addr_o, valid_o, pc_o, instr_o
    );
    modport master (
        output pc_i, valid_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, flush_i, ready_i,
        input  ready_o, imem_req_o, imem_addr_o, valid_o, pc_o, instr_o
    );
`endif
endinterface

// File: rtl/if_mem.sv
// if_mem: instruction-memory access stage pairing in-order imem responses with their PCs.
// Optional IF_MEM_MISALIGN_EN: misaligned PCs bypass memory as faulting NOP entries.
module if_mem #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input logic     clk,
    input logic     rst,
    if_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [XLEN-1:0] ins_q [DEPTH];
    logic [DEPTH-1:0] fil_q;
    logic [AW-1:0] head, tail, fill;
    logic [CW-1:0] count, drop, pend;
    logic [CW:0] used, pend_drop;
    logic credit_ok, mis, acc, pop, rsp_wr, rsp_drop;
    assign used      = {1'b0, count} + {1'b0, drop};
    assign pend_drop = {1'b0, pend} + {1'b0, drop};
    assign credit_ok = used < (CW+1)'(DEPTH);
`ifdef IF_MEM_MISALIGN_EN
    logic [DEPTH-1:0] flt_q;
    assign mis         = bus.pc_i[1:0] != 2'b00;
    assign bus.fault_o = flt_q[head];
`else
    assign mis = 1'b0;
`endif
    assign bus.imem_req_o  = bus.valid_i & credit_ok & ~bus.flush_i & ~mis;
    assign bus.imem_addr_o = bus.pc_i;
    // a misaligned PC only enters behind fully resolved traffic so fill can move with tail
    assign bus.ready_o = (bus.imem_req_o & bus.imem_gnt_i) |
                         (bus.valid_i & credit_ok & ~bus.flush_i & mis & (pend == '0) & (drop == '0));
    assign acc         = bus.ready_o;
    assign bus.valid_o = fil_q[head] & ~bus.flush_i;
    assign bus.pc_o    = pc_q[head];
    assign bus.instr_o = ins_q[head];
    assign pop         = bus.valid_o & bus.ready_i;
    assign rsp_drop    = bus.imem_rvalid_i & (drop != '0);
    assign rsp_wr      = bus.imem_rvalid_i & (drop == '0) & (pend != '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            fill  <= '0;
            count <= '0;
            drop  <= '0;
            pend  <= '0;
            fil_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                ins_q[i] <= '0;
            end
`ifdef IF_MEM_MISALIGN_EN
            flt_q <= '0;
`endif
        end else if (bus.flush_i) begin
            tail  <= head;
            fill  <= head;
            count <= '0;
            pend  <= '0;
            fil_q <= '0;
            // every unfilled entry still owes a response; one arriving now is already consumed
            drop  <= CW'(pend_drop - (CW+1)'(bus.imem_rvalid_i && pend_drop != '0));
        end else begin
            if (acc) begin
                pc_q[tail]  <= bus.pc_i;
                fil_q[tail] <= mis;
                tail        <= tail + AW'(1);
                if (mis) ins_q[tail] <= NOP;
`ifdef IF_MEM_MISALIGN_EN
                flt_q[tail] <= mis;
`endif
            end
            if (rsp_wr) begin
                ins_q[fill] <= bus.imem_rdata_i;
                fil_q[fill] <= 1'b1;
            end
            if (rsp_wr || (acc && mis)) fill <= fill + AW'(1);
            if (pop) begin
                fil_q[head] <= 1'b0;
                head        <= head + AW'(1);
            end
            count <= count + CW'(acc) - CW'(pop);
            pend  <= pend + CW'(acc & ~mis) - CW'(rsp_wr);
            drop  <= drop - CW'(rsp_drop);
        end
    end
endmodule

// File: tb/tb_if_mem.sv
// tb_if_mem: scoreboard bench for if_mem with an in-order, fixed-latency memory model.
// Misalignment checks are compiled only when IF_MEM_MISALIGN_EN is defined.
module tb_if_mem;
    localparam int XLEN = 32;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        flt;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    mreq_t mq[$];
    exp_t e;
    int cyc, n_chk, n_fail;
    int lat = 2;
    bit ok;
    int k;
    always #5 clk = ~clk;
    if_mem_if #(.XLEN(XLEN)) bus ();
    if_mem #(.DEPTH(2), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    function automatic logic [31:0] fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : {a[15:0], 16'h0013};
    endfunction

    function automatic bit is_mis(input logic [31:0] a);
`ifdef IF_MEM_MISALIGN_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic offer(input logic [31:0] pc, input int budget, output bit acc);
        acc = 1'b0;
        bus.valid_i = 1'b1;
        bus.pc_i = pc;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            acc = bus.ready_o;
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while ((exp_q.size() != 0 || mq.size() != 0) && i < 60) begin
            @(negedge clk);
            i++;
        end
        check(tag, 64'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    // memory: in-order responses, lat cycles after grant, cleared by reset
    initial begin
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                mq.delete();
                bus.imem_rvalid_i = 1'b0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i = fn(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_rvalid_i = 1'b0;
                bus.imem_rdata_i = '0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) exp_q.delete();
            else begin
                if (bus.valid_o && bus.ready_i) begin
                    check("out_pending", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_pc", bus.pc_o, e.pc);
                        check("out_instr", bus.instr_o, e.ins);
`ifdef IF_MEM_MISALIGN_EN
                        check("out_fault", bus.fault_o, e.flt);
`endif
                    end
                end
                if (bus.valid_i && bus.ready_o)
                    exp_q.push_back('{pc: bus.pc_i, ins: is_mis(bus.pc_i) ? 32'h13 : fn(bus.pc_i), flt: is_mis(bus.pc_i)});
                if (bus.imem_req_o) check("addr_pass", bus.imem_addr_o, bus.pc_i);
                if (bus.imem_req_o && bus.imem_gnt_i) mq.push_back('{addr: bus.imem_addr_o, due: cyc + lat});
                if (bus.flush_i) exp_q.delete();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.pc_i = '0;
        bus.valid_i = 1'b0;
        bus.imem_gnt_i = 1'b1;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        #2;
        check("rst_valid", bus.valid_o, 0);
        check("rst_pc", bus.pc_o, 0);
        check("rst_instr", bus.instr_o, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        // no grant: request visible but not accepted
        bus.imem_gnt_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.pc_i = 32'h120;
        @(negedge clk);
        check("nogrant_req", bus.imem_req_o, 1);
        check("nogrant_ready", bus.ready_o, 0);
        @(posedge clk);
        #1;
        bus.imem_gnt_i = 1'b1;
        // single fetch with latency measurement
        bus.pc_i = 32'h100;
        @(negedge clk);
        check("t1_ready", bus.ready_o, 1);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.valid_o && k < 10);
        check("t1_latency", 64'(k), 3);
        @(negedge clk);
        check("t1_valid_after", bus.valid_o, 0);
        @(posedge clk);
        #1;
        // full with backpressure
        bus.ready_i = 1'b0;
        offer(32'h0, 5, ok);
        check("t2_acc0", ok, 1);
        offer(32'h4, 5, ok);
        check("t2_acc4", ok, 1);
        offer(32'h8, 6, ok);
        check("t2_full", ok, 0);
        bus.ready_i = 1'b1;
        @(negedge clk);
        check("t2_head_valid", bus.valid_o, 1);
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        offer(32'h8, 3, ok);
        check("t2_acc8", ok, 1);
        bus.ready_i = 1'b1;
        drain("t2_drain");
        // flush with two requests in flight
        lat = 4;
        offer(32'h10, 3, ok);
        check("t3_acc10", ok, 1);
        offer(32'h14, 3, ok);
        check("t3_acc14", ok, 1);
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.pc_i = 32'h300;
        @(negedge clk);
        check("t3_flush_ready", bus.ready_o, 0);
        check("t3_flush_req", bus.imem_req_o, 0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        offer(32'h200, 20, ok);
        check("t3_acc200", ok, 1);
        drain("t3_drain");
        lat = 2;
        // flush coincident with the only response
        offer(32'h20, 3, ok);
        check("t4_acc20", ok, 1);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("t4_rvalid_in_flush", bus.imem_rvalid_i, 1);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_no_out", bus.valid_o, 0);
        end
        @(posedge clk);
        #1;
        offer(32'h24, 3, ok);
        check("t4_acc24", ok, 1);
        drain("t4_drain");
        // asynchronous reset while two entries are held
        bus.ready_i = 1'b0;
        offer(32'h30, 3, ok);
        offer(32'h34, 3, ok);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.valid_o && k < 10);
        check("t5_valid", bus.valid_o, 1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t5_rst_valid", bus.valid_o, 0);
        check("t5_rst_pc", bus.pc_o, 0);
        check("t5_rst_instr", bus.instr_o, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        offer(32'h40, 3, ok);
        check("t5_acc40", ok, 1);
        drain("t5_drain");
`ifdef IF_MEM_MISALIGN_EN
        bus.valid_i = 1'b1;
        bus.pc_i = 32'h102;
        @(negedge clk);
        check("mis_req", bus.imem_req_o, 0);
        check("mis_ready", bus.ready_o, 1);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        check("mis_valid", bus.valid_o, 1);
        check("mis_fault", bus.fault_o, 1);
        check("mis_instr", bus.instr_o, 32'h13);
        @(posedge clk);
        #1;
        offer(32'h104, 3, ok);
        check("mis_acc104", ok, 1);
        drain("mis_drain");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
